// File: rtl/align_shift_ctrl_if.sv
// Handshake bundle between the alignment-shift controller and its neighbours.
//   master : producer of exponent vectors / consumer of shift vectors (testbench, upstream)
//   slave  : align_shift_ctrl
// Signals:
//   ivalid/iready        input vector handshake
//   iexp[LANES*EXP_W]    unsigned exponents, lane k at [k*EXP_W +: EXP_W]
//   izero[LANES]         per-lane zero mask
//   ovalid/oready        shift vector handshake
//   oshift[LANES*EXP_W]  per-lane right-shift amounts, same packing as iexp
//   omax_exp[EXP_W]      max exponent over non-zero lanes
//   oall_zero            every lane was masked
interface align_shift_ctrl_if #(
    parameter int EXP_W = 10,
    parameter int LANES = 16
);
    logic                   ivalid;
    logic                   iready;
    logic [LANES*EXP_W-1:0] iexp;
    logic [LANES-1:0]       izero;
    logic                   ovalid;
    logic                   oready;
    logic [LANES*EXP_W-1:0] oshift;
    logic [EXP_W-1:0]       omax_exp;
    logic                   oall_zero;

    modport master (
        output ivalid, iexp, izero, oready,
        input  iready, ovalid, oshift, omax_exp, oall_zero
    );

    modport slave (
        input  ivalid, iexp, izero, oready,
        output iready, ovalid, oshift, omax_exp, oall_zero
    );
endinterface

// File: rtl/align_shift_ctrl.sv
// Sequencing controller for the 16-lane alignment shifter bank.
// Captures an exponent vector + zero mask, scans lanes serially for the
// maximum non-zero exponent, then produces saturated per-lane right-shift
// amounts (max - exp) and holds them until the downstream accepts.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    align_shift_ctrl_if.slave (see interface header)

// Per-lane shift amount: max - exp, saturated at WIDTH-1; masked lanes saturate.
module align_shift_lane #(
    parameter int WIDTH = 49,
    parameter int EXP_W = 10
) (
    input  logic [EXP_W-1:0] max_i,
    input  logic [EXP_W-1:0] exp_i,
    input  logic             zero_i,
    output logic [EXP_W-1:0] shift_o
);
    localparam logic [EXP_W:0]   SAT   = (EXP_W+1)'(WIDTH-1);
    localparam logic [EXP_W-1:0] SAT_S = EXP_W'(WIDTH-1);

    logic [EXP_W:0] diff;

    // Extra bit keeps the subtraction honest; max covers every non-zero lane,
    // so only masked lanes could underflow and those are overridden anyway.
    assign diff    = {1'b0, max_i} - {1'b0, exp_i};
    assign shift_o = (zero_i || diff >= SAT) ? SAT_S : diff[EXP_W-1:0];
endmodule

module align_shift_ctrl #(
    parameter int WIDTH = 49,
    parameter int EXP_W = 10,
    parameter int LANES = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    align_shift_ctrl_if.slave bus
);
    localparam int CW = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, SCAN, CALC, DONE} state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 cnt_q;
    logic [EXP_W-1:0]              max_q;
    logic                          found_q;
    logic [LANES-1:0][EXP_W-1:0]   exp_q;
    logic [LANES-1:0]              zero_q;
    logic [LANES-1:0][EXP_W-1:0]   shift_q, shift_d;
    logic [EXP_W-1:0]              omax_q;
    logic                          allz_q;
    logic                          last_lane;

    assign last_lane = (cnt_q == CW'(LANES-1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.ivalid)  state_d = SCAN;
            SCAN: if (last_lane)   state_d = CALC;
            CALC:                  state_d = DONE;
            DONE: if (bus.oready)  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Handshake outputs decode the state register only
    always_comb begin
        bus.iready = (state_q == IDLE);
        bus.ovalid = (state_q == DONE);
    end

    // Shift calculators, one per lane
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        align_shift_lane #(.WIDTH(WIDTH), .EXP_W(EXP_W)) u_lane (
            .max_i   (max_q),
            .exp_i   (exp_q[k]),
            .zero_i  (zero_q[k]),
            .shift_o (shift_d[k])
        );
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            max_q   <= '0;
            found_q <= 1'b0;
            exp_q   <= '0;
            zero_q  <= '0;
            shift_q <= '0;
            omax_q  <= '0;
            allz_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.ivalid) begin
                    exp_q   <= bus.iexp;
                    zero_q  <= bus.izero;
                    max_q   <= '0;
                    found_q <= 1'b0;
                    cnt_q   <= '0;
                end
                SCAN: begin
                    // found gates the first non-zero lane in even when its exponent is 0
                    if (!zero_q[cnt_q] && (!found_q || exp_q[cnt_q] > max_q)) begin
                        max_q   <= exp_q[cnt_q];
                        found_q <= 1'b1;
                    end
                    cnt_q <= cnt_q + CW'(1);
                end
                CALC: begin
                    shift_q <= shift_d;
                    omax_q  <= max_q;
                    allz_q  <= ~found_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.oshift    = shift_q;
    assign bus.omax_exp  = omax_q;
    assign bus.oall_zero = allz_q;
endmodule

// File: tb/tb_align_shift_ctrl.sv
module tb_align_shift_ctrl;
    localparam int WIDTH = 49;
    localparam int EXP_W = 10;
    localparam int LANES = 16;
    localparam int VW    = LANES*EXP_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    align_shift_ctrl_if #(.EXP_W(EXP_W), .LANES(LANES)) ifc ();

    align_shift_ctrl #(.WIDTH(WIDTH), .EXP_W(EXP_W), .LANES(LANES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    typedef struct {
        logic [LANES-1:0][EXP_W-1:0] e;
        logic [LANES-1:0]            z;
        logic [EXP_W-1:0]            mx;
        logic                        az;
        logic [LANES-1:0][EXP_W-1:0] sh;
    } vec_t;

    localparam int NV = 7;
    vec_t tv [NV];

    int total = 0;
    int passed = 0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input int i);
        ifc.iexp  = tv[i].e;
        ifc.izero = tv[i].z;
    endtask

    // Wait (bounded) for ovalid; n = edges elapsed
    task automatic wait_ovalid(output int n);
        n = 0;
        while (!ifc.ovalid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_iready();
        int n = 0;
        while (!ifc.iready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ifc.iready) check("iready_timeout", 0, 1);
    endtask

    task automatic check_out(input int i, input string tag);
        check({tag, "_shift"}, ifc.oshift, tv[i].sh);
        check({tag, "_max"},   VW'(ifc.omax_exp), VW'(tv[i].mx));
        check({tag, "_allz"},  VW'(ifc.oall_zero), VW'(tv[i].az));
    endtask

    // Full transaction with oready already high
    task automatic run_vec(input int i, input string tag);
        int lat;
        wait_iready();
        drive(i);
        ifc.ivalid = 1'b1;
        @(posedge clk); #1;              // accepting edge 0
        ifc.ivalid = 1'b0;
        check({tag, "_iready_busy"}, VW'(ifc.iready), 0);
        wait_ovalid(lat);
        check({tag, "_latency"}, VW'(lat), 17);
        check_out(i, tag);
        @(posedge clk); #1;
        check({tag, "_ovalid_drop"}, VW'(ifc.ovalid), 0);
        check({tag, "_iready_back"}, VW'(ifc.iready), 1);
    endtask

    initial begin
        int lat;
        logic [VW-1:0] hold_sh;
        logic [EXP_W-1:0] hold_mx;
        logic hold_az;

        // 0: basic ramp
        for (int k = 0; k < LANES; k++) begin
            tv[0].e[k] = EXP_W'(100 + k); tv[0].sh[k] = EXP_W'(15 - k);
        end
        tv[0].z = '0; tv[0].mx = 10'd115; tv[0].az = 1'b0;
        // 1: zero mask and saturation
        for (int k = 0; k < LANES; k++) begin
            tv[1].e[k] = 10'd10; tv[1].sh[k] = 10'd48;
        end
        tv[1].e[3] = 10'd200; tv[1].e[5] = 10'd120; tv[1].e[9] = 10'd250;
        tv[1].z = 16'h0200; tv[1].mx = 10'd200; tv[1].az = 1'b0; tv[1].sh[3] = 10'd0;
        // 2: lane 5 within range
        tv[2] = tv[1];
        tv[2].e[5] = 10'd180; tv[2].sh[5] = 10'd20;
        // 3: all zero-masked
        for (int k = 0; k < LANES; k++) begin
            tv[3].e[k] = EXP_W'(500 + 7*k); tv[3].sh[k] = 10'd48;
        end
        tv[3].z = 16'hFFFF; tv[3].mx = 10'd0; tv[3].az = 1'b1;
        // 4: ties at maximum
        for (int k = 0; k < LANES; k++) begin
            tv[4].e[k] = 10'd290; tv[4].sh[k] = 10'd10;
        end
        tv[4].e[2] = 10'd300; tv[4].e[7] = 10'd300; tv[4].sh[2] = 10'd0; tv[4].sh[7] = 10'd0;
        tv[4].z = '0; tv[4].mx = 10'd300; tv[4].az = 1'b0;
        // 5: all exponents 0 but unmasked -> not all-zero
        tv[5].e = '0; tv[5].sh = '0; tv[5].z = '0; tv[5].mx = 10'd0; tv[5].az = 1'b0;
        // 6: single live lane at the top, difference exactly 47/48 edge
        for (int k = 0; k < LANES; k++) begin
            tv[6].e[k] = 10'd952; tv[6].sh[k] = 10'd48;
        end
        tv[6].e[15] = 10'd1000; tv[6].e[0] = 10'd953; tv[6].e[1] = 10'd952;
        tv[6].sh[15] = 10'd0; tv[6].sh[0] = 10'd47; tv[6].sh[1] = 10'd48;
        tv[6].z = '0; tv[6].mx = 10'd1000; tv[6].az = 1'b0;

        ifc.ivalid = 1'b0; ifc.oready = 1'b1; ifc.iexp = '0; ifc.izero = '0;
        #12;
        check("rst_ovalid", VW'(ifc.ovalid), 0);
        check("rst_shift",  ifc.oshift, '0);
        check("rst_max",    VW'(ifc.omax_exp), 0);
        check("rst_allz",   VW'(ifc.oall_zero), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_iready", VW'(ifc.iready), 1);

        // Table-driven vectors
        for (int i = 0; i < NV; i++) run_vec(i, $sformatf("vec%0d", i));

        // Output registers persist after handshake
        check("persist_shift", ifc.oshift, tv[NV-1].sh);

        // Reset mid-scan at cnt = 7
        drive(0); ifc.ivalid = 1'b1;
        @(posedge clk); #1; ifc.ivalid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #3;
        check("midrst_shift", ifc.oshift, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_ovalid", VW'(ifc.ovalid), 0);
        check("midrst_oshift", ifc.oshift, '0);
        check("midrst_iready", VW'(ifc.iready), 1);
        run_vec(2, "post_rst");

        // Backpressure: hold oready low for 10 cycles after ovalid
        ifc.oready = 1'b0;
        drive(4); ifc.ivalid = 1'b1;
        @(posedge clk); #1; ifc.ivalid = 1'b0;
        wait_ovalid(lat);
        check("bp_latency", VW'(lat), 17);
        check_out(4, "bp");
        hold_sh = ifc.oshift; hold_mx = ifc.omax_exp; hold_az = ifc.oall_zero;
        for (int c = 0; c < 10; c++) begin
            ifc.ivalid = ~ifc.ivalid;
            ifc.iexp   = {5{$urandom()}};
            @(posedge clk); #1;
            check($sformatf("bp_hold_ovalid%0d", c), VW'(ifc.ovalid), 1);
            check($sformatf("bp_hold_iready%0d", c), VW'(ifc.iready), 0);
            check($sformatf("bp_hold_out%0d", c),
                  {ifc.oshift} ^ VW'({ifc.omax_exp, ifc.oall_zero}),
                  hold_sh ^ VW'({hold_mx, hold_az}));
        end
        ifc.ivalid = 1'b0;
        ifc.oready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ovalid", VW'(ifc.ovalid), 0);
        check("bp_release_iready", VW'(ifc.iready), 1);
        check_out(4, "bp_after");
        @(posedge clk); #1;
        check("bp_idle_stays", VW'(ifc.iready), 1);

        // Back-to-back with ivalid held high
        drive(0); ifc.ivalid = 1'b1;
        @(posedge clk); #1;              // accept A
        drive(1);
        wait_ovalid(lat);
        check("b2b_a_latency", VW'(lat), 17);
        check_out(0, "b2b_a");
        @(posedge clk); #1;              // handshake edge 18
        check("b2b_idle_iready", VW'(ifc.iready), 1);
        @(posedge clk); #1;              // edge 19 accepts B
        check("b2b_b_accepted", VW'(ifc.iready), 0);
        ifc.ivalid = 1'b0;
        wait_ovalid(lat);
        check("b2b_b_latency", VW'(lat), 17);
        check_out(1, "b2b_b");
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got timeout required completion");
        $fatal(1);
    end
endmodule

// File: doc/align_shift_ctrl.md
Name: align_shift_ctrl

Overview:
- Sequencing controller for the 16-lane alignment shifter bank.
- Accepts one 16-lane exponent vector plus a per-lane zero mask over a valid/ready handshake.
- Scans the non-zero lanes serially to find the maximum exponent, then emits per-lane right-shift amounts (max - exp, saturated).
- Shift amounts drive the ishift0..ishiftF inputs of the shifter bank; the max exponent goes to the downstream accumulator.

Parameters:
- WIDTH, 49, data width of the shifter lanes; sets the shift saturation point WIDTH-1.
- EXP_W, 10, exponent and shift-amount width; requires 2^EXP_W > WIDTH-1.
- LANES, 16, lane count; fixed at 16 for this codebase.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ivalid  in  1  input vector valid.
- iready  out  1  controller can accept a vector.
- iexp  in  LANES*EXP_W  unsigned exponents; lane k at bits [k*EXP_W +: EXP_W].
- izero  in  LANES  bit k=1 marks lane k as zero; its exponent is ignored.
- ovalid  out  1  shift vector valid.
- oready  in  1  downstream accepts the shift vector.
- oshift  out  LANES*EXP_W  per-lane shift amounts, same packing as iexp.
- omax_exp  out  EXP_W  maximum exponent over non-zero lanes.
- oall_zero  out  1  all 16 lanes were zero-masked.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; scan counter = 0; max register = 0.
  - oshift, omax_exp, oall_zero and ovalid are all 0.
  - iready = 1 once rst_n is deasserted.
  - Reset asserted mid-scan or mid-hold aborts the vector; no partial output appears.
- FSM states: IDLE, SCAN, CALC, DONE.
- IDLE:
  - iready = 1; this is the only state in which iready is high.
  - On ivalid & iready, register iexp and izero, clear max = 0, clear found = 0, clear cnt = 0, go to SCAN.
- SCAN:
  - One lane per cycle; cnt runs 0..15.
  - If izero[cnt] = 0 and (found = 0 or exp[cnt] > max): max <= exp[cnt], found <= 1.
  - At cnt = 15, go to CALC. cnt is 4 bits and wraps to 0.
- CALC (one cycle):
  - For each lane k: shift_k = izero[k] ? WIDTH-1 : min(max - exp[k], WIDTH-1).
  - The difference is computed at EXP_W+1 bits; it is never negative because max >= every non-zero exponent.
  - Register oshift, omax_exp = max, oall_zero = ~found, then go to DONE.
  - All-zero case: max = 0 and every shift = WIDTH-1.
- DONE:
  - ovalid = 1; oshift, omax_exp and oall_zero are held stable while ovalid & ~oready.
  - On oready, ovalid drops next cycle and the state returns to IDLE.
  - The output registers keep their last value after the handshake; they are not cleared.
- Latency: the accepting edge is edge 0; ovalid is high after edge 17.
- Throughput: with oready tied high, one vector per 19 cycles.
- ivalid while not in IDLE is ignored: iready is low, so no handshake occurs.
- Ties for the maximum: equal exponents give shift 0 for every tied lane.
- Saturation: a difference >= WIDTH yields WIDTH-1. An arithmetic shift by WIDTH-1 already gives full sign fill, so no information is lost.
- Datapath: purely registered outputs; no combinational path from ivalid or oready to any output other than iready (a function of state only).

Test Plan:
- Reset:
  - Stimulus: assert rst_n = 0 during SCAN at cnt = 7, then release.
  - Response: ovalid = 0, oshift = 0, iready = 1 on the first cycle after release; the next vector is processed normally.
- Basic:
  - Stimulus: exps lane k = 100 + k, izero = 0, oready = 1.
  - Response: ovalid after edge 17; omax_exp = 115; shift_k = 15 - k; oall_zero = 0; iready high again 19 cycles after accept.
- Zero mask and saturation:
  - Stimulus: lane 3 = 200, lane 5 = 120, lane 9 = 250 with izero[9] = 1, all other lanes = 10.
  - Response: omax_exp = 200; shift3 = 0; shift5 = 48 (80 saturated); shift9 = 48; all other lanes = 48; lane 5 with exp 180 instead gives shift 20.
- All zero:
  - Stimulus: izero = 16'hFFFF.
  - Response: oall_zero = 1, omax_exp = 0, every shift = 48.
- Backpressure:
  - Stimulus: hold oready = 0 for 10 cycles after ovalid; toggle ivalid and iexp during the hold.
  - Response: outputs stable; iready = 0 throughout; accept only after oready, then return to IDLE.
- Back-to-back:
  - Stimulus: two vectors with ivalid held high and different data.
  - Response: the second is accepted exactly on the first IDLE cycle after DONE; the results match each vector independently.
